// File: rtl/l0_skew_bank_pkg.sv
// Shared mode encodings and sizing helpers for the L0 skew bank.
package l0_skew_bank_pkg;

    typedef enum logic {
        WR_BCAST = 1'b0,
        WR_RR    = 1'b1
    } wr_mode_e;

    typedef enum logic {
        RD_PAR  = 1'b0,
        RD_SKEW = 1'b1
    } rd_mode_e;

    // Length of the skew pipe: lane ROWS-1 pops this many cycles after lane 0.
    function automatic int unsigned skew_len(input int unsigned rows, input int unsigned skew);
        return (rows - 1) * skew;
    endfunction

endpackage

// File: rtl/l0_skew_bank_if.sv
// Bus bundle between the L0 bank and its producer/consumer.
interface l0_skew_bank_if #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned BW   = 4
);
    logic                 wr;
    logic                 rd;
    logic                 wr_mode;
    logic                 rd_mode;
    logic [ROWS*BW-1:0]   in;
    logic [ROWS*BW-1:0]   out;
    logic [ROWS-1:0]      out_valid;
    logic                 o_full;
    logic                 o_empty;
    logic                 o_ready;
    logic                 o_err_ovf;
    logic                 o_err_unf;

    modport master (
        output wr, rd, wr_mode, rd_mode, in,
        input  out, out_valid, o_full, o_empty, o_ready, o_err_ovf, o_err_unf
    );

    modport slave (
        input  wr, rd, wr_mode, rd_mode, in,
        output out, out_valid, o_full, o_empty, o_ready, o_err_ovf, o_err_unf
    );
endinterface

// File: rtl/l0_lane_fifo.sv
// Single-clock lane FIFO with registered pop data. A full lane refuses a push
// and an empty lane refuses a pop regardless of the other side in that cycle.
module l0_lane_fifo #(
    parameter int unsigned BW    = 4,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [BW-1:0]            din_i,
    output logic [BW-1:0]            dout_o,
    output logic                     dvalid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [BW-1:0] dout_q, dout_d;
    logic          dvalid_q, dvalid_d;
    logic          full, empty, push_ok, pop_ok;

    // Accept decisions and next-state for pointers, count and output register.
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push_i & ~full;
        pop_ok   = pop_i & ~empty;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        dout_d   = pop_ok ? mem_q[rd_ptr_q] : dout_q;
        dvalid_d = pop_ok;
    end

    // Storage array write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Control state and registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign dout_o   = dout_q;
    assign dvalid_o = dvalid_q;
    assign count_o  = count_q;

endmodule

// File: rtl/l0_skew_bank.sv
// L0 input buffer: ROWS lane FIFOs with broadcast/round-robin writes,
// parallel/skewed reads, occupancy-aware ready and sticky error flags.
module l0_skew_bank
    import l0_skew_bank_pkg::*;
#(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned BW    = 4,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned SKEW  = 1
) (
    input  logic              clk,
    input  logic              reset,
    l0_skew_bank_if.slave     bus
);
    localparam int unsigned PIPE = skew_len(ROWS, SKEW);
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned RW   = $clog2(ROWS);

    wr_mode_e        wr_mode_q, wr_mode_d;
    rd_mode_e        rd_mode_q, rd_mode_d;
    logic [RW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PIPE-1:0] pipe_q, pipe_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [CW-1:0]   lane_count [ROWS];
    logic [BW-1:0]   lane_dout  [ROWS];
    logic [ROWS-1:0] lane_valid;
    logic [ROWS-1:0] lane_full, lane_empty;
    logic [ROWS-1:0] lane_push, lane_pop;
    logic            any_full, all_empty, pipe_idle;

    // Per-lane occupancy status and bank-level flags derived from state only.
    always_comb begin
        for (int unsigned i = 0; i < ROWS; i++) begin
            lane_full[i]  = (lane_count[i] == CW'(DEPTH));
            lane_empty[i] = (lane_count[i] == '0);
        end
        any_full  = |lane_full;
        all_empty = &lane_empty;
        pipe_idle = ~|pipe_q;
    end

    // Write steering: broadcast is all-or-nothing, round-robin targets rr_ptr.
    always_comb begin
        lane_push = '0;
        rr_ptr_d  = rr_ptr_q;
        ovf_d     = ovf_q;
        if (bus.wr) begin
            if (wr_mode_q == WR_BCAST) begin
                if (any_full) ovf_d = 1'b1;
                else          lane_push = '1;
            end else if (lane_full[rr_ptr_q]) begin
                ovf_d = 1'b1;
            end else begin
                lane_push[rr_ptr_q] = 1'b1;
                rr_ptr_d = (rr_ptr_q == RW'(ROWS - 1)) ? '0 : rr_ptr_q + 1'b1;
            end
        end
    end

    // Read steering: lane 0 pops on rd, lane i taps the skew pipe i*SKEW-1 stages in.
    always_comb begin
        lane_pop  = '0;
        pipe_d[0] = bus.rd & (rd_mode_q == RD_SKEW);
        for (int unsigned k = 1; k < PIPE; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        if (rd_mode_q == RD_PAR) begin
            lane_pop = {ROWS{bus.rd}};
        end else begin
            lane_pop[0] = bus.rd;
            for (int unsigned i = 1; i < ROWS; i++) begin
                lane_pop[i] = pipe_q[i*SKEW-1];
            end
        end
        unf_d = unf_q | (|(lane_pop & lane_empty));
    end

    // Modes only change once the bank is drained and no skewed pop is in flight.
    always_comb begin
        wr_mode_d = wr_mode_q;
        rd_mode_d = rd_mode_q;
        if (all_empty && pipe_idle) begin
            wr_mode_d = wr_mode_e'(bus.wr_mode);
            rd_mode_d = rd_mode_e'(bus.rd_mode);
        end
    end

    // Bank control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_mode_q <= WR_BCAST;
            rd_mode_q <= RD_PAR;
            rr_ptr_q  <= '0;
            pipe_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_mode_q <= wr_mode_d;
            rd_mode_q <= rd_mode_d;
            rr_ptr_q  <= rr_ptr_d;
            pipe_q    <= pipe_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_lane
        l0_lane_fifo #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push_i   (lane_push[g]),
            .pop_i    (lane_pop[g]),
            .din_i    (bus.in[g*BW +: BW]),
            .dout_o   (lane_dout[g]),
            .dvalid_o (lane_valid[g]),
            .count_o  (lane_count[g])
        );
    end

    // Output bus assembly.
    always_comb begin
        bus.out = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            bus.out[i*BW +: BW] = lane_dout[i];
        end
        bus.out_valid = lane_valid;
        bus.o_full    = any_full;
        bus.o_empty   = all_empty;
        bus.o_ready   = (wr_mode_q == WR_BCAST) ? ~any_full : ~lane_full[rr_ptr_q];
        bus.o_err_ovf = ovf_q;
        bus.o_err_unf = unf_q;
    end

endmodule
